// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//   Quadrature decoder for an incremental encoder. Synchronises the A/B phase
//   inputs, tracks the Gray-code phase and produces up/down step events, a
//   wrapping N-bit position count and a sticky illegal-transition flag.
//
//   Build option:
//     QDEC_X1_EN  defined   : x1 resolution, one count per electrical cycle
//                             (01->00 counts up, 00->01 counts down).
//                 undefined : x4 resolution, every valid transition counts.
//
//   Ports:
//     clk      in  1  rising-edge clock
//     rst      in  1  asynchronous active-high reset
//     a, b     in  1  encoder phases, asynchronous to clk
//     clr      in  1  synchronous position clear (wins over a step)
//     err_clr  in  1  synchronous clear of err (an illegal event wins)
//     pos      out N  wrapping position count
//     dir      out 1  direction of the last valid transition (1 = up)
//     step     out 1  one-cycle pulse per counted transition
//     err      out 1  sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quad_decoder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
  input  logic         clr,
  input  logic         err_clr,
  output logic [N-1:0] pos,
  output logic         dir,
  output logic         step,
  output logic         err
);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  fill_cnt, fill_cnt_nx;
  logic [1:0]  s1, s2, prev;
  logic        load_prev;
  logic        fwd, rev, ill;
  logic        cnt_up, cnt_dn;

  // Modulo-2^N position update; clear has priority over any step.
  function automatic logic [N-1:0] pos_next(input logic [N-1:0] p,
                                            input logic          up,
                                            input logic          dn,
                                            input logic          clear);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    if (clear)   return '0;
    else if (up) return p + one;
    else if (dn) return p - one;
    else         return p;
  endfunction

  // Stage 1/2: two-flop synchroniser for {a,b}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= 2'd0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
    end
  end

  // Next-state and transition decode. FILL lets the synchroniser flush so a
  // static level present at reset release is primed into prev, not counted.
  always_comb begin
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    load_prev   = 1'b0;
    fwd         = 1'b0;
    rev         = 1'b0;
    ill         = 1'b0;
    case (state)
      FILL: begin
        if (fill_cnt == 2'd2) begin
          state_nx    = RUN;
          fill_cnt_nx = 2'd0;
          load_prev   = 1'b1;
        end else begin
          fill_cnt_nx = fill_cnt + 2'd1;
        end
      end
      RUN: begin
        load_prev = 1'b1;
        case ({prev, s2})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
          4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill = 1'b1;
          default: ;
        endcase
      end
      default: state_nx = FILL;
    endcase
  end

`ifdef QDEC_X1_EN
  // Only the transitions into/out of phase 00 through 01 carry a count.
  assign cnt_up = fwd && (prev == 2'b01);
  assign cnt_dn = rev && (prev == 2'b00);
`else
  assign cnt_up = fwd;
  assign cnt_dn = rev;
`endif

  // Stage 3: phase register and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 2'b00;
      pos  <= '0;
      dir  <= 1'b0;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (load_prev) prev <= s2;
      pos  <= pos_next(pos, cnt_up, cnt_dn, clr);
      step <= cnt_up | cnt_dn;
      if (fwd)      dir <= 1'b1;
      else if (rev) dir <= 1'b0;
      if (ill)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule
